uart_tx_monitor: RTL
====================

Name: uart_tx_monitor

Overview:
- Receiving end of the serial stimulus path: oversamples a UART line (idle high, 1 start, N data LSB-first, 1 stop, no parity) and deframes it into N-bit words.
- Buffers words in a small first-word-fall-through FIFO for a harness or host-side consumer.
- Captures the ALU result stream on the transmitter's tx output during bring-up and self-checking runs.
- Generates its own oversampling tick, so it needs no external baudrate_generator.

Parameters:
- N, 8, data bits per frame.
- CLK_FREQ, 50000000, clk frequency in Hz.
- BAUD_RATE, 9600, line bit rate.
- OVERSAMPLE, 16, ticks per bit period; even, at least 4.
- FIFO_DEPTH, 4, words buffered; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- rx_line  input  1  monitored serial line, asynchronous to clk, idle high.
- rd_en  input  1  pop head word; ignored when o_empty=1.
- clr_flags  input  1  synchronous clear of the sticky flags.
- o_data  output  N  FIFO head word; valid while o_empty=0.
- o_empty  output  1  FIFO holds no words.
- o_full  output  1  FIFO holds FIFO_DEPTH words.
- o_count  output  $clog2(FIFO_DEPTH+1)  words held.
- o_busy  output  1  deframer not in IDLE.
- o_frame_err  output  1  sticky: stop bit sampled 0.
- o_overflow  output  1  sticky: completed word dropped because FIFO was full.

Behaviour:
- Reset values:
  - o_data=0, o_empty=1, o_full=0, o_count=0, o_busy=0, o_frame_err=0, o_overflow=0.
  - Synchronizer flops=1, state=IDLE, tick counter=0.
- Tick generator: DIV=CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division.
  - Counter runs 0..DIV-1 continuously from reset.
  - tick is high for one clk when the counter equals DIV-1.
- rx_line passes through a 2-flop synchronizer (rxs); adds 2 clk latency.
- Deframer FSM; s = tick counter within a bit, b = bit index:
  - IDLE: rxs=0 seen on a tick -> START with s=0.
  - START: on each tick s++. When s reaches OVERSAMPLE/2-1, sample rxs (mid start bit). If 0 -> DATA with s=0, b=0. If 1 -> IDLE (glitch, nothing recorded).
  - DATA: on each tick s++. When s reaches OVERSAMPLE-1, sample rxs into shift[b] (LSB first), set s=0, b++. After bit N-1 -> STOP.
  - STOP: when s reaches OVERSAMPLE-1, sample rxs.
    - If 1: push word and go to IDLE.
    - If 0: set o_frame_err, push nothing, go to WAIT.
  - WAIT: stay until rxs=1 on a tick, then go to IDLE. Prevents a break condition from re-triggering frames.
- o_busy=1 in every state except IDLE.
- Push timing: the word appears in the FIFO, with o_empty deasserted and o_count incremented, on the clk after the stop-sample tick.
- FIFO:
  - First-word-fall-through: o_data always shows the head word.
  - rd_en with o_empty=0 pops; the next head is shown the following clk.
  - Push when full and no pop in the same clk: word dropped, o_overflow set, contents unchanged.
  - Push and pop in the same clk when full: both take effect, count unchanged, no overflow.
  - Push and pop in the same clk when empty: push only; the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags hold until clr_flags or reset.
  - clr_flags in the same clk as a new error event: the flag ends set (the event wins).
- Reset mid-frame: partial word discarded, FIFO emptied, FSM returns to IDLE; the next start edge is handled normally.

Test Plan:
- Common setup for all scenarios: CLK_FREQ=1600000, BAUD_RATE=10000, OVERSAMPLE=16, so DIV=10 and one bit period = 160 clk.
- Drive frame 0xA5 with correct timing -> o_empty falls, o_data=8'hA5, o_count=1, o_frame_err=0. Pulse rd_en -> o_empty=1, o_count=0.
- Send 5 frames 0x01..0x05 without reading -> o_full=1, o_count=4, o_overflow=1. Reading in order returns 01, 02, 03, 04.
- Send frame 0x3C with stop bit 0, then hold line low for 3 bit periods -> no push, o_frame_err=1, o_busy=1 until line high. Then clr_flags -> o_frame_err=0.
- Send a 40-clk low glitch on the idle line -> returns to IDLE, o_count=0, no flags set.
- Assert reset after 4 data bits of 0xFF -> all outputs return to reset values. A following frame 0x5A is received correctly.
- With FIFO full, pulse rd_en in the same clk as the stop-bit push -> o_count stays 4, o_overflow=0, new word is last in order.

Source files
------------

// File: rtl/uart_tx_monitor.sv
// UART line monitor: oversampled deframer (8N1-style, no parity) feeding a
// first-word-fall-through FIFO, with sticky framing-error and overflow flags.
module uart_tx_monitor #(
  parameter int unsigned N          = 8,
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               rx_line,
  input  logic                               rd_en,
  input  logic                               clr_flags,
  output logic [N-1:0]                       o_data,
  output logic                               o_empty,
  output logic                               o_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count,
  output logic                               o_busy,
  output logic                               o_frame_err,
  output logic                               o_overflow
);

  localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW      = $clog2(OVERSAMPLE);
  localparam int unsigned BW      = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            sync1_q, rxs_q;
  logic [SW-1:0]   s_q, s_d;
  logic [BW-1:0]   b_q, b_d;
  logic [N-1:0]    shift_q, shift_d;
  logic            busy_q, busy_d;
  logic [N-1:0]    mem_q [FIFO_DEPTH];
  logic [N-1:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [N-1:0]    data_q, data_d;
  logic            empty_q, empty_d, full_q, full_d;
  logic            ferr_q, ferr_d, ovf_q, ovf_d;
  logic            tick_c, push_c, ferr_evt_c, pop_c, wr_c, ovf_evt_c, is_full_c;

  wire s_half_c = (s_q == SW'(OVERSAMPLE / 2 - 1));
  wire s_last_c = (s_q == SW'(OVERSAMPLE - 1));

  // Free-running oversampling tick
  always_comb begin
    tick_c = (cnt_q == TW'(DIV - 1));
    cnt_d  = tick_c ? '0 : cnt_q + TW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      s_q     <= '0;
      b_q     <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync1_q <= rx_line;
      rxs_q   <= sync1_q;
      s_q     <= s_d;
      b_q     <= b_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
    end
  end

  // Deframer next state; every transition happens on a tick
  always_comb begin
    state_d = state_q;
    if (tick_c) begin
      case (state_q)
        IDLE:    if (!rxs_q) state_d = START;
        START:   if (s_half_c) state_d = rxs_q ? IDLE : DATA;
        DATA:    if (s_last_c && (b_q == BW'(N - 1))) state_d = STOP;
        STOP:    if (s_last_c) state_d = rxs_q ? IDLE : WAIT;
        WAIT:    if (rxs_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Deframer datapath and events
  always_comb begin
    s_d        = s_q;
    b_d        = b_q;
    shift_d    = shift_q;
    push_c     = 1'b0;
    ferr_evt_c = 1'b0;
    busy_d     = (state_d != IDLE);
    if (tick_c) begin
      case (state_q)
        IDLE: begin
          s_d = '0;
          b_d = '0;
        end
        START: begin
          s_d = s_half_c ? '0 : s_q + SW'(1);
          b_d = '0;
        end
        DATA: begin
          if (s_last_c) begin
            s_d     = '0;
            b_d     = b_q + BW'(1);
            shift_d = (shift_q >> 1) | (N'(rxs_q) << (N - 1));
          end else begin
            s_d = s_q + SW'(1);
          end
        end
        STOP: begin
          if (s_last_c) begin
            s_d        = '0;
            push_c     = rxs_q;
            ferr_evt_c = !rxs_q;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
        default: s_d = '0;
      endcase
    end
  end

  // FWFT FIFO; a push into a full FIFO only lands when a pop frees a slot
  always_comb begin
    is_full_c = (count_q == CW'(FIFO_DEPTH));
    pop_c     = rd_en && (count_q != '0);
    wr_c      = push_c && (!is_full_c || pop_c);
    ovf_evt_c = push_c && is_full_c && !pop_c;
    mem_d     = mem_q;
    if (wr_c) mem_d[wptr_q] = shift_q;
    wptr_d  = wr_c  ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop_c ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    if (wr_c && !pop_c) count_d = count_q + CW'(1);
    else if (!wr_c && pop_c) count_d = count_q - CW'(1);
    data_d  = mem_d[rptr_d];
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(FIFO_DEPTH));
    ferr_d  = ferr_evt_c | (ferr_q & !clr_flags);
    ovf_d   = ovf_evt_c  | (ovf_q  & !clr_flags);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      data_q  <= data_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_data      = data_q;
  assign o_empty     = empty_q;
  assign o_full      = full_q;
  assign o_count     = count_q;
  assign o_busy      = busy_q;
  assign o_frame_err = ferr_q;
  assign o_overflow  = ovf_q;

endmodule
